ahb_apb3_bridge_multislot: RTL
==============================

Name: ahb_apb3_bridge_multislot

Overview:
- Parametrised AHB-Lite slave to APB3 master bridge; successor to the single-select bridge state machine.
- Adds configurable address/data width, N-way PSEL decode with per-slot response muxing, and a programmable PREADY timeout that terminates hung APB accesses with an AHB ERROR.
- Sits between the AHB-Lite fabric and the peripheral APB3 segment.

Parameters:
- ADDR_WIDTH, 32, HADDR width.
- DATA_WIDTH, 32, HWDATA/HRDATA/PWDATA/PRDATA width.
- PADDR_WIDTH, 12, low HADDR bits forwarded to PADDR.
- NUM_SLOTS, 4, number of APB slaves (1..16).
- SLOT_LSB, 12, lowest HADDR bit of the slot index field; field width = clog2(NUM_SLOTS), minimum 1.
- TIMEOUT, 256, ACCESS cycles allowed before timeout (0 = disabled).

Ports:
- HCLK  in  1  clock
- HRESETN  in  1  reset
- HSEL  in  1  bridge select
- HADDR  in  ADDR_WIDTH  AHB address
- HWRITE  in  1  1 = write
- HTRANS  in  2  bit1 set = NONSEQ/SEQ
- HWDATA  in  DATA_WIDTH  write data, data phase
- HREADY  in  1  bus ready
- HREADYOUT  out  1  bridge ready
- HRESP  out  2  00 = OKAY, 01 = ERROR
- HRDATA  out  DATA_WIDTH  read data
- PADDR  out  PADDR_WIDTH  APB address
- PWRITE  out  1  APB direction
- PENABLE  out  1  APB enable
- PWDATA  out  DATA_WIDTH  APB write data
- PSEL  out  NUM_SLOTS  one-hot slave selects
- PRDATA  in  NUM_SLOTS*DATA_WIDTH  concatenated read data; slot k at [k*DATA_WIDTH +: DATA_WIDTH]
- PREADY  in  NUM_SLOTS  per-slot ready
- PSLVERR  in  NUM_SLOTS  per-slot error
- TIMEOUT_EVT  out  1  one-cycle pulse on timeout

Behaviour:
- Reset and clocking:
  - Reset HRESETN is asynchronous, active-low; clock HCLK.
  - Reset values: state IDLE, HREADYOUT=1, HRESP=00, HRDATA=0, PADDR=0, PWRITE=0, PENABLE=0, PWDATA=0, PSEL=0, TIMEOUT_EVT=0.
  - Reset asserted mid-transfer aborts immediately; the APB slave sees PSEL drop with no completion.
- Outputs are registered or decoded from registered state only; no input-to-output combinational path.
- Accept condition: HSEL & HREADY & HTRANS[1], sampled in IDLE, DONE or ERR2. On accept, capture HADDR, HWRITE and slot index. In any other state it is ignored; HREADYOUT=0 prevents it.
- States:
  - IDLE: HREADYOUT=1, HRESP=00. On accept: write -> WDATA; read with valid slot -> SETUP; slot index >= NUM_SLOTS -> ERR1.
  - WDATA: HREADYOUT=0. Register PWDATA<=HWDATA at end of cycle. Invalid slot -> ERR1, else -> SETUP.
  - SETUP: PSEL[slot]=1, PENABLE=0, PADDR and PWRITE valid, HREADYOUT=0. -> ACCESS.
  - ACCESS: PSEL[slot]=1, PENABLE=1, HREADYOUT=0, timeout counter increments each cycle.
    - PREADY[slot]=1 and PSLVERR[slot]=0 -> DONE; HRDATA<=PRDATA[slot] on reads.
    - PREADY[slot]=1 and PSLVERR[slot]=1 -> ERR1; HRDATA<=0.
    - TIMEOUT!=0, counter reaches TIMEOUT-1 and PREADY low -> ERR1; TIMEOUT_EVT=1 for one cycle; HRDATA<=0.
    - PREADY takes priority over timeout in the same cycle.
  - DONE: HREADYOUT=1, HRESP=00, PSEL=0, PENABLE=0. Accept -> as IDLE, else -> IDLE.
  - ERR1: HREADYOUT=0, HRESP=01, PSEL=0. -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=01. Accept -> as IDLE, else -> IDLE.
- PENABLE, PSEL and the counter clear on leaving ACCESS. PADDR, PWRITE and PWDATA hold until the next accept.
- Latency from the accepting edge, zero-wait slave:
  - Read: SETUP at cycle 1, ACCESS at cycle 2, HREADYOUT=1 with data at cycle 3.
  - Write: one cycle later than read.
- Unselected or out-of-range slots: PREADY, PRDATA and PSLVERR are ignored.
- HTRANS=IDLE/BUSY with HSEL set: no state change, OKAY response.

Test Plan:
- Read slot 2, HADDR=0x0000_2010, slave zero-wait PRDATA=0xCAFE_0001 -> PSEL=0100 and PADDR=0x010 for 2 cycles; HREADYOUT=1 with HRDATA=0xCAFE_0001 3 cycles after accept; HRESP=00.
- Write slot 1, HWDATA=0x1234_5678, slave inserts 3 PREADY-low cycles -> PWDATA=0x1234_5678 stable from SETUP through ACCESS; ACCESS lasts 4 cycles; HREADYOUT rises the cycle after PREADY.
- PSLVERR=1 with PREADY on read slot 0 -> HRESP=01 with HREADYOUT=0 for one cycle, then HRESP=01 with HREADYOUT=1; HRDATA=0.
- TIMEOUT=8, PREADY held low -> PENABLE high exactly 8 cycles; TIMEOUT_EVT single pulse; two-cycle ERROR response; a later access to the same slot works normally.
- NUM_SLOTS=3, address to slot 3 -> no PSEL asserted; two-cycle ERROR response; a back-to-back accept in ERR2 proceeds.
- Back-to-back read/write accepted in DONE; HRESETN asserted during ACCESS -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/ahb_apb3_bridge_multislot_if.sv
// Bus bundle between the AHB-Lite fabric, the bridge and the APB3 peripheral segment.
// The slave modport is the bridge view; the master modport is the surrounding
// environment (AHB master plus the APB slaves' response signals).
interface ahb_apb3_bridge_multislot_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int PADDR_WIDTH = 12,
  parameter int NUM_SLOTS   = 4
);
  logic                            HSEL;
  logic [ADDR_WIDTH-1:0]           HADDR;
  logic                            HWRITE;
  logic [1:0]                      HTRANS;
  logic [DATA_WIDTH-1:0]           HWDATA;
  logic                            HREADY;
  logic                            HREADYOUT;
  logic [1:0]                      HRESP;
  logic [DATA_WIDTH-1:0]           HRDATA;
  logic [PADDR_WIDTH-1:0]          PADDR;
  logic                            PWRITE;
  logic                            PENABLE;
  logic [DATA_WIDTH-1:0]           PWDATA;
  logic [NUM_SLOTS-1:0]            PSEL;
  logic [NUM_SLOTS*DATA_WIDTH-1:0] PRDATA;
  logic [NUM_SLOTS-1:0]            PREADY;
  logic [NUM_SLOTS-1:0]            PSLVERR;
  logic                            TIMEOUT_EVT;

  modport slave (
    input  HSEL, HADDR, HWRITE, HTRANS, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA,
    output PADDR, PWRITE, PENABLE, PWDATA, PSEL,
    input  PRDATA, PREADY, PSLVERR,
    output TIMEOUT_EVT
  );

  modport master (
    output HSEL, HADDR, HWRITE, HTRANS, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA,
    input  PADDR, PWRITE, PENABLE, PWDATA, PSEL,
    output PRDATA, PREADY, PSLVERR,
    input  TIMEOUT_EVT
  );
endinterface

// File: rtl/ahb_apb3_bridge_multislot.sv
// AHB-Lite slave to APB3 master bridge with N-way PSEL decode, per-slot response
// muxing and a PREADY timeout that turns a hung APB access into an AHB ERROR.
// All outputs come from registers or from a decode of registered state.
module ahb_apb3_bridge_multislot #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int PADDR_WIDTH = 12,
  parameter int NUM_SLOTS   = 4,
  parameter int SLOT_LSB    = 12,
  parameter int TIMEOUT     = 256
) (
  input  logic                         HCLK,
  input  logic                         HRESETN,
  ahb_apb3_bridge_multislot_if.slave   bus
);

  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WDATA  = 3'd1;
  localparam logic [2:0] ST_SETUP  = 3'd2;
  localparam logic [2:0] ST_ACCESS = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;
  localparam logic [2:0] ST_ERR1   = 3'd5;
  localparam logic [2:0] ST_ERR2   = 3'd6;

  logic [2:0]             state_q, state_d;
  logic [SW-1:0]          slot_q;
  logic [PADDR_WIDTH-1:0] paddr_q;
  logic                   pwrite_q;
  logic [DATA_WIDTH-1:0]  pwdata_q;
  logic [DATA_WIDTH-1:0]  hrdata_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   tevt_q;

  logic                   accept;
  logic [SW-1:0]          slot_in;
  logic [DATA_WIDTH-1:0]  prdata_sel;
  logic                   pready_sel;
  logic                   pslverr_sel;
  logic                   timeout_hit;
  logic [NUM_SLOTS-1:0]   psel_dec;
  logic                   unused_addr_bits;

  // Slot indices beyond NUM_SLOTS exist whenever NUM_SLOTS is not a power of two.
  function automatic logic slot_ok(input logic [SW-1:0] s);
    return int'(s) < NUM_SLOTS;
  endfunction

  assign slot_in          = bus.HADDR[SLOT_LSB +: SW];
  assign unused_addr_bits = ^bus.HADDR;

  // New transfers are only taken in the states that drive HREADYOUT high.
  assign accept = bus.HSEL & bus.HREADY & bus.HTRANS[1] &
                  ((state_q == ST_IDLE) | (state_q == ST_DONE) | (state_q == ST_ERR2));

  // Select the addressed slave's response; other slots never influence the bridge.
  always_comb begin
    prdata_sel  = '0;
    pready_sel  = 1'b0;
    pslverr_sel = 1'b0;
    psel_dec    = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (slot_q == SW'(k)) begin
        prdata_sel  = bus.PRDATA[k*DATA_WIDTH +: DATA_WIDTH];
        pready_sel  = bus.PREADY[k];
        pslverr_sel = bus.PSLVERR[k];
        psel_dec[k] = (state_q == ST_SETUP) | (state_q == ST_ACCESS);
      end
    end
  end

  // A completing PREADY in the last allowed cycle wins over the timeout.
  assign timeout_hit = (TIMEOUT != 0) && (state_q == ST_ACCESS) &&
                       !pready_sel && (cnt_q == TO_LAST);

  // Next-state decode for the transfer sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        if (!accept)          state_d = ST_IDLE;
        else if (bus.HWRITE)  state_d = ST_WDATA;
        else if (slot_ok(slot_in)) state_d = ST_SETUP;
        else                  state_d = ST_ERR1;
      end
      ST_WDATA:  state_d = slot_ok(slot_q) ? ST_SETUP : ST_ERR1;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (pready_sel)       state_d = pslverr_sel ? ST_ERR1 : ST_DONE;
        else if (timeout_hit) state_d = ST_ERR1;
      end
      ST_ERR1:   state_d = ST_ERR2;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Wait counter runs only while staying in ACCESS and clears on leaving it.
  always_comb begin
    cnt_d = '0;
    if ((state_q == ST_ACCESS) && (state_d == ST_ACCESS)) cnt_d = cnt_q + 1'b1;
  end

  // Sequencer state and timeout counter.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Address-phase capture; PADDR/PWRITE hold until the next accepted transfer.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      slot_q   <= '0;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
    end else if (accept) begin
      slot_q   <= slot_in;
      paddr_q  <= bus.HADDR[PADDR_WIDTH-1:0];
      pwrite_q <= bus.HWRITE;
    end
  end

  // Write data arrives in the AHB data phase, i.e. the cycle spent in WDATA.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN)                 pwdata_q <= '0;
    else if (state_q == ST_WDATA) pwdata_q <= bus.HWDATA;
  end

  // Read data is latched on a good read completion and zeroed on any error exit.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      hrdata_q <= '0;
    end else if (state_q == ST_ACCESS) begin
      if (pready_sel) begin
        if (pslverr_sel)   hrdata_q <= '0;
        else if (!pwrite_q) hrdata_q <= prdata_sel;
      end else if (timeout_hit) begin
        hrdata_q <= '0;
      end
    end
  end

  // One-cycle timeout pulse, coincident with the first error-response cycle.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) tevt_q <= 1'b0;
    else          tevt_q <= timeout_hit;
  end

  assign bus.HREADYOUT   = (state_q == ST_IDLE) | (state_q == ST_DONE) | (state_q == ST_ERR2);
  assign bus.HRESP       = {1'b0, (state_q == ST_ERR1) | (state_q == ST_ERR2)};
  assign bus.HRDATA      = hrdata_q;
  assign bus.PADDR       = paddr_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PENABLE     = (state_q == ST_ACCESS);
  assign bus.PWDATA      = pwdata_q;
  assign bus.PSEL        = psel_dec;
  assign bus.TIMEOUT_EVT = tevt_q;

endmodule
